nocr_router_ctrl: RTL and testbench
===================================

NOCR_ROUTER_CTRL -- requirements
Module: nocr_router_ctrl

Interface
REQ-001 SHALL have parameter NUM_TGT, default 4, number of target routers (2..16).
REQ-002 SHALL have parameter ADDR_W, default 16, packet address width (ADDR_W > clog2(NUM_TGT)).
REQ-003 SHALL have parameter DATA_W, default 32, payload/response width.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum cycles from entering REQ to a target response (>= 2).
REQ-005 SHALL have parameter TGT_EN_MASK, default all ones, NUM_TGT bits; bit i = 1 means target i is populated.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port pkt_valid, input, 1, packet generator offers a packet.
REQ-009 SHALL have port pkt_ready, output, 1, block accepts a packet.
REQ-010 SHALL have ports pkt_addr (ADDR_W), pkt_data (DATA_W) and pkt_we (1), inputs, packet contents.
REQ-011 SHALL have port tgt_req_valid, output, NUM_TGT, one-hot request to target i.
REQ-012 SHALL have port tgt_req_ready, input, NUM_TGT, target i accepts the request.
REQ-013 SHALL have ports tgt_addr (ADDR_W), tgt_data (DATA_W) and tgt_we (1), outputs, shared request bus driven from the captured packet.
REQ-014 SHALL have port tgt_resp_valid, input, NUM_TGT, target i presents a response.
REQ-015 SHALL have port tgt_resp_data, input, NUM_TGT*DATA_W, slice i is the response of target i.
REQ-016 SHALL have port resp_valid, output, 1, response to the packet generator is valid.
REQ-017 SHALL have port resp_ready, input, 1, packet generator accepts the response.
REQ-018 SHALL have ports resp_data (DATA_W) and resp_err (2), outputs; resp_err 00 = OK, 01 = DECERR, 10 = TIMEOUT.
REQ-019 SHALL have port err_cnt, output, 8, saturating count of non-OK responses delivered.

Function
REQ-020 SHALL implement the states IDLE, DECODE, REQ, WAIT_RESP and RESP.
REQ-021 SHALL drive pkt_ready = 1 only in IDLE.
REQ-022 SHALL capture pkt_addr, pkt_data and pkt_we on pkt_valid & pkt_ready and move to DECODE.
REQ-023 SHALL, in DECODE, compute idx = captured addr[ADDR_W-1 -: clog2(NUM_TGT)]; the packet is invalid if idx >= NUM_TGT or TGT_EN_MASK[idx] = 0.
REQ-024 SHALL, in DECODE, go to RESP with resp_err = 01 and resp_data = 0 for an invalid packet, and otherwise go to REQ.
REQ-025 SHALL, in REQ, hold tgt_req_valid[idx] = 1 with all other bits 0, and go to WAIT_RESP on tgt_req_ready[idx].
REQ-026 SHALL, in WAIT_RESP, register tgt_resp_data slice idx on tgt_resp_valid[idx], set resp_err = 00 and go to RESP.
REQ-027 SHALL ignore tgt_resp_valid in every state other than WAIT_RESP, and ignore the bits of all non-selected targets.
REQ-028 SHALL clear the timeout counter on entering REQ and increment it each cycle spent in REQ or WAIT_RESP.
REQ-029 SHALL, when the counter reaches TIMEOUT-1 without the awaited event, go to RESP with resp_err = 10 and resp_data = 0, dropping tgt_req_valid if the timeout occurs in REQ.
REQ-030 SHALL give a response the priority over a timeout when tgt_resp_valid[idx] arrives in the same cycle the counter reaches TIMEOUT-1.
REQ-031 SHALL, in RESP, hold resp_valid = 1 and keep resp_data/resp_err stable until resp_ready, then return to IDLE.
REQ-032 SHALL increment err_cnt on each RESP handshake with resp_err != 00, and saturate it at 255.
REQ-033 SHALL give the following minimum latency for a packet accepted in cycle T: DECODE at T+1, tgt_req_valid at T+2; with same-cycle target ready and a response at T+3, resp_valid at T+4; for a DECERR, resp_valid at T+2.
REQ-034 SHALL force any unreachable state encoding to IDLE on the next cycle.

Reset
REQ-035 SHALL, while reset = 1, immediately force IDLE, pkt_ready = 1, tgt_req_valid = 0, resp_valid = 0, resp_data = 0, resp_err = 00, err_cnt = 0 and timeout counter = 0.
REQ-036 SHALL abandon any in-flight transaction on reset assertion mid-operation, with no response issued after reset deasserts.

Verification
REQ-037 SHALL cover: a packet to target 2 with target ready and responding 0xDEADBEEF at once -> resp_valid at T+4, resp_data = 0xDEADBEEF, resp_err = 00.
REQ-038 SHALL cover: TGT_EN_MASK = 4'b0111 and a packet to idx 3 -> no tgt_req_valid, resp_err = 01 at T+2, err_cnt = 1.
REQ-039 SHALL cover: TIMEOUT = 8 with target 1 never responding -> resp_err = 10 exactly 8 cycles after entering REQ, and a late target 1 response is ignored.
REQ-040 SHALL cover: a response arriving on the timeout cycle -> resp_err = 00 with the response data.
REQ-041 SHALL cover: resp_ready held low for 5 cycles -> resp_valid, resp_data and resp_err are stable, and pkt_ready = 0 throughout.
REQ-042 SHALL cover: 300 DECERR packets -> err_cnt = 255; reset asserted in WAIT_RESP -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/nocr_router_ctrl.sv
// Packet router controller: decodes a target index from the packet address,
// forwards the request, and returns the response or a DECERR/TIMEOUT error.
module nocr_router_ctrl #(
    parameter int                 NUM_TGT     = 4,
    parameter int                 ADDR_W      = 16,
    parameter int                 DATA_W      = 32,
    parameter int                 TIMEOUT     = 64,
    parameter logic [NUM_TGT-1:0] TGT_EN_MASK = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [ADDR_W-1:0]         pkt_addr,
    input  logic [DATA_W-1:0]         pkt_data,
    input  logic                      pkt_we,
    output logic [NUM_TGT-1:0]        tgt_req_valid,
    input  logic [NUM_TGT-1:0]        tgt_req_ready,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_data,
    output logic                      tgt_we,
    input  logic [NUM_TGT-1:0]        tgt_resp_valid,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_resp_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [1:0]                resp_err,
    output logic [7:0]                err_cnt
);

    localparam int IDX_W = $clog2(NUM_TGT);
    localparam int NSLOT = 1 << IDX_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Slots beyond NUM_TGT read as unpopulated, so one lookup covers both checks.
    localparam logic [NSLOT-1:0] EN_EXT   = NSLOT'(TGT_EN_MASK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DEC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        REQ       = 3'd2,
        WAIT_RESP = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               pkt_ok;
    logic               sel_ready;
    logic               sel_resp;
    logic [DATA_W-1:0]  sel_data;
    logic               tmo;

    assign idx    = tgt_addr[ADDR_W-1 -: IDX_W];
    assign pkt_ok = EN_EXT[idx];
    assign tmo    = (cnt >= CNT_LAST);

    always_comb begin
        sel_ready = 1'b0;
        sel_resp  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_ready = tgt_req_ready[i];
                sel_resp  = tgt_resp_valid[i];
                sel_data  = tgt_resp_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:      state_nxt = pkt_valid ? DECODE : IDLE;
            DECODE:    state_nxt = pkt_ok ? REQ : RESP;
            REQ: begin
                if (sel_ready)  state_nxt = WAIT_RESP;
                else if (tmo)   state_nxt = RESP;
                else            state_nxt = REQ;
            end
            WAIT_RESP: begin
                if (sel_resp || tmo) state_nxt = RESP;
                else                 state_nxt = WAIT_RESP;
            end
            RESP:      state_nxt = resp_ready ? IDLE : RESP;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready     = (state == IDLE);
        resp_valid    = (state == RESP);
        tgt_req_valid = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            tgt_req_valid[i] = (state == REQ) && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_addr  <= '0;
            tgt_data  <= '0;
            tgt_we    <= 1'b0;
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= ERR_OK;
            err_cnt   <= '0;
        end else begin
            if (state == IDLE && pkt_valid) begin
                tgt_addr <= pkt_addr;
                tgt_data <= pkt_data;
                tgt_we   <= pkt_we;
            end

            if (state == REQ || state == WAIT_RESP) cnt <= cnt + 1'b1;
            else                                    cnt <= '0;

            if (state == DECODE && !pkt_ok) begin
                resp_data <= '0;
                resp_err  <= ERR_DEC;
            end else if (state == REQ && !sel_ready && tmo) begin
                resp_data <= '0;
                resp_err  <= ERR_TMO;
            end else if (state == WAIT_RESP) begin
                // A response on the last counted cycle wins over the timeout.
                if (sel_resp) begin
                    resp_data <= sel_data;
                    resp_err  <= ERR_OK;
                end else if (tmo) begin
                    resp_data <= '0;
                    resp_err  <= ERR_TMO;
                end
            end

            if (state == RESP && resp_ready && resp_err != ERR_OK
                && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nocr_router_ctrl.sv
// Randomized bench for nocr_router_ctrl: each packet's outcome and timing is
// predicted from address decode, target delays and the timeout window.
module tb_nocr_router_ctrl;

    localparam int         NT    = 4;
    localparam int         AW    = 16;
    localparam int         DW    = 32;
    localparam int         TO    = 8;
    localparam logic [3:0] MASK  = 4'b0111;
    localparam int         NEVER = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [AW-1:0]    pkt_addr;
    logic [DW-1:0]    pkt_data;
    logic             pkt_we;
    logic [NT-1:0]    tgt_req_valid;
    logic [NT-1:0]    tgt_req_ready;
    logic [AW-1:0]    tgt_addr;
    logic [DW-1:0]    tgt_data;
    logic             tgt_we;
    logic [NT-1:0]    tgt_resp_valid;
    logic [NT*DW-1:0] tgt_resp_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [DW-1:0]    resp_data;
    logic [1:0]       resp_err;
    logic [7:0]       err_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int model_err = 0;

    nocr_router_ctrl #(
        .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT(TO), .TGT_EN_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_addr(pkt_addr), .pkt_data(pkt_data), .pkt_we(pkt_we),
        .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready),
        .tgt_addr(tgt_addr), .tgt_data(tgt_data), .tgt_we(tgt_we),
        .tgt_resp_valid(tgt_resp_valid), .tgt_resp_data(tgt_resp_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Target side: idx acts per the schedule, everything else is noise.
    task automatic drive_tgt(input int idx, input bit ok, input int k,
                             input int rd, input int kr,
                             input logic [DW-1:0] d);
        logic [NT-1:0] rdy;
        logic [NT-1:0] rv;
        rdy = NT'($urandom);
        rv  = NT'($urandom);
        for (int i = 0; i < NT; i++) tgt_resp_data[i*DW +: DW] = $urandom;
        if (ok) begin
            if (k == rd)     rdy[idx] = 1'b1;
            else if (k < rd) rdy[idx] = 1'b0;
            if (k == kr)               rv[idx] = 1'b1;
            else if (k > rd && k < kr) rv[idx] = 1'b0;
            if (k == kr) tgt_resp_data[idx*DW +: DW] = d;
        end
        tgt_req_ready  = rdy;
        tgt_resp_valid = rv;
    endtask

    // rd: REQ cycles before ready; sd: WAIT cycles before the response.
    task automatic xact(input int idx, input logic [DW-1:0] d,
                        input int rd, input int sd, input int rr,
                        input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] pd;
        logic          we;
        logic [DW-1:0] e_data;
        logic [1:0]    e_err;
        logic [NT-1:0] oh;
        bit            ok;
        int            kr;
        int            resp_at;
        a  = {idx[1:0], 14'($urandom)};
        pd = $urandom;
        we = 1'($urandom);
        ok = MASK[idx];
        oh = NT'(1) << idx;
        kr = rd + 1 + sd;
        if (!ok) begin
            resp_at = 2; e_err = 2'b01; e_data = '0;
        end else if (rd <= TO - 2 && kr <= TO - 1) begin
            resp_at = kr + 3; e_err = 2'b00; e_data = d;
        end else begin
            resp_at = TO + 2; e_err = 2'b10; e_data = '0;
        end

        chk({tag, ":pkt_ready_idle"}, 64'(pkt_ready), 64'(1));
        pkt_valid = 1'b1;
        pkt_addr  = a;
        pkt_data  = pd;
        pkt_we    = we;
        drive_tgt(idx, 1'b0, -2, rd, kr, d);
        step();
        pkt_valid = 1'b0;
        pkt_addr  = AW'($urandom);
        pkt_data  = $urandom;
        chk({tag, ":tgt_addr"}, 64'(tgt_addr), 64'(a));
        chk({tag, ":tgt_data"}, 64'(tgt_data), 64'(pd));
        chk({tag, ":tgt_we"}, 64'(tgt_we), 64'(we));

        for (int c = 1; c < resp_at; c++) begin
            chk({tag, ":req_valid"}, 64'(tgt_req_valid),
                (ok && c >= 2 && c - 2 <= rd) ? 64'(oh) : 64'(0));
            chk({tag, ":resp_valid_early"}, 64'(resp_valid), 64'(0));
            chk({tag, ":pkt_ready_busy"}, 64'(pkt_ready), 64'(0));
            drive_tgt(idx, ok, c - 2, rd, kr, d);
            step();
        end

        for (int j = 0; j <= rr; j++) begin
            chk({tag, ":resp_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, ":resp_data"}, 64'(resp_data), 64'(e_data));
            chk({tag, ":resp_err"}, 64'(resp_err), 64'(e_err));
            chk({tag, ":pkt_ready_resp"}, 64'(pkt_ready), 64'(0));
            chk({tag, ":req_valid_resp"}, 64'(tgt_req_valid), 64'(0));
            chk({tag, ":err_cnt_hold"}, 64'(err_cnt), 64'(model_err));
            resp_ready = (j == rr);
            drive_tgt(idx, ok, resp_at + j - 2, rd, kr, d);
            step();
        end
        resp_ready = 1'b0;
        if (e_err != 2'b00 && model_err < 255) model_err++;
        chk({tag, ":err_cnt"}, 64'(err_cnt), 64'(model_err));
        chk({tag, ":resp_valid_done"}, 64'(resp_valid), 64'(0));
        chk({tag, ":pkt_ready_done"}, 64'(pkt_ready), 64'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":pkt_ready"}, 64'(pkt_ready), 64'(1));
        chk({tag, ":req_valid"}, 64'(tgt_req_valid), 64'(0));
        chk({tag, ":resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, ":resp_data"}, 64'(resp_data), 64'(0));
        chk({tag, ":resp_err"}, 64'(resp_err), 64'(0));
        chk({tag, ":err_cnt"}, 64'(err_cnt), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        pkt_valid      = 1'b0;
        pkt_addr       = '0;
        pkt_data       = '0;
        pkt_we         = 1'b0;
        tgt_req_ready  = '0;
        tgt_resp_valid = '0;
        tgt_resp_data  = '0;
        resp_ready     = 1'b0;
        #1;
        chk_reset_vals("por");
        step();
        step();
        reset = 1'b0;
        step();

        xact(2, 32'hDEADBEEF, 0, 0, 0, "tgt2_fast");
        xact(3, 32'h12345678, 0, 0, 0, "decerr_idx3");
        xact(1, 32'h0BADF00D, NEVER, 0, 0, "timeout_req");
        xact(1, 32'hA5A5A5A5, 0, TO - 2, 0, "resp_on_tmo");
        xact(0, 32'h5A5A5A5A, 0, TO - 1, 0, "resp_after_tmo");
        xact(0, 32'hFEEDFACE, 2, 1, 5, "stall5");

        for (int n = 0; n < 200; n++) begin
            int rd;
            rd = ($urandom_range(0, 4) == 0) ? NEVER
                                             : int'($urandom_range(0, TO - 2));
            xact(int'($urandom_range(0, 3)), $urandom, rd,
                 int'($urandom_range(0, TO)), int'($urandom_range(0, 3)),
                 "rand");
        end

        for (int n = 0; n < 300; n++) begin
            xact(3, $urandom, 0, 0, 0, "decerr_sat");
        end
        chk("err_cnt_sat", 64'(err_cnt), 64'(255));

        xact(2, 32'hCAFEF00D, 0, 0, 0, "pre_reset");

        // Abandon a transaction in WAIT_RESP with an asynchronous reset.
        pkt_valid = 1'b1;
        pkt_addr  = {2'd1, 14'h0123};
        pkt_data  = $urandom;
        step();
        pkt_valid = 1'b0;
        drive_tgt(1, 1'b1, -1, 0, NEVER, '0);
        step();
        drive_tgt(1, 1'b1, 0, 0, NEVER, '0);
        step();
        chk("mid_wait:req_valid", 64'(tgt_req_valid), 64'(0));
        chk("mid_wait:resp_valid", 64'(resp_valid), 64'(0));
        drive_tgt(1, 1'b1, 1, 0, NEVER, '0);
        #1;
        reset = 1'b1;
        #1;
        model_err = 0;
        chk_reset_vals("mid_reset");
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tgt_resp_valid = '1;
            tgt_req_ready  = '1;
            step();
            chk("post_reset:resp_valid", 64'(resp_valid), 64'(0));
            chk("post_reset:pkt_ready", 64'(pkt_ready), 64'(1));
        end
        tgt_resp_valid = '0;
        tgt_req_ready  = '0;
        xact(2, 32'h600DCAFE, 0, 1, 1, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
